// File: rtl/key_event_decoder.sv
// Turns debounced press/release strobes into click, double-click, long-press and auto-repeat events.
// Optional auto-repeat in the LONG state is enabled by defining KEY_AUTOREPEAT_EN.
module key_event_decoder #(
    parameter int CNT_W         = 26,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_press,
    input  logic i_release,
    output logic o_click,
    output logic o_double_click,
    output logic o_long_press,
    output logic o_repeat,
    output logic o_busy
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_HELD1 = 5'b00010,
        S_WAIT2 = 5'b00100,
        S_HELD2 = 5'b01000,
        S_LONG  = 5'b10000
    } state_e;

    localparam longint MAX_LD  = (LONG_CYCLES > DCLICK_CYCLES) ? longint'(LONG_CYCLES)
                                                               : longint'(DCLICK_CYCLES);
    localparam longint MAX_CYC = (MAX_LD > longint'(REPEAT_CYCLES)) ? MAX_LD
                                                                    : longint'(REPEAT_CYCLES);

    if (MAX_CYC - 1 >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
        $error("key_event_decoder: CNT_W too narrow for the configured cycle counts");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             click_q, click_d;
    logic             dclick_q, dclick_d;
    logic             long_q, long_d;
    logic             busy_q, busy_d;
    logic             press_v, release_v;
    logic             long_to, dclick_to;

    // Simultaneous press and release is treated as if neither happened.
    assign press_v   = i_press & ~i_release;
    assign release_v = i_release & ~i_press;

    assign long_to   = (cnt_q == CNT_W'(LONG_CYCLES - 1));
    assign dclick_to = (cnt_q == CNT_W'(DCLICK_CYCLES - 1));

`ifdef KEY_AUTOREPEAT_EN
    logic rep_q, rep_d;
    logic rep_to;

    assign rep_to   = (cnt_q == CNT_W'(REPEAT_CYCLES - 1));
    assign o_repeat = rep_q;
`else
    assign o_repeat = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
        click_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_d    = 1'b0;
`endif
        // Input events are tested before timeouts so that an event wins a tie.
        case (state_q)
            S_IDLE: begin
                if (press_v) state_d = S_HELD1;
            end
            S_HELD1: begin
                if (release_v) begin
                    state_d = S_WAIT2;
                end else if (long_to) begin
                    long_d  = 1'b1;
                    state_d = S_LONG;
                end
            end
            S_WAIT2: begin
                if (press_v) begin
                    state_d = S_HELD2;
                end else if (dclick_to) begin
                    click_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HELD2: begin
                if (release_v) begin
                    dclick_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (long_to) begin
                    long_d  = 1'b1;
                    state_d = S_LONG;
                end
            end
            S_LONG: begin
                if (release_v) begin
                    state_d = S_IDLE;
`ifdef KEY_AUTOREPEAT_EN
                end else if (rep_to) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end
`else
                end else begin
                    cnt_d = '0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            click_q  <= 1'b0;
            dclick_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            click_q  <= click_d;
            dclick_q <= dclick_d;
            long_q   <= long_d;
            busy_q   <= busy_d;
`ifdef KEY_AUTOREPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    assign o_click        = click_q;
    assign o_double_click = dclick_q;
    assign o_long_press   = long_q;
    assign o_busy         = busy_q;

endmodule
